// File: rtl/decode_if.sv
// Instruction-in / decoded-op-out bundle for decode_stage.
// XLEN must match the decode_stage instance it is connected to.
interface decode_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_type;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic            out_illegal;
  logic            out_is_muldiv;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_type, out_rs1, out_rs2, out_rd,
           out_imm, out_opcode, out_funct3, out_funct7, out_illegal, out_is_muldiv
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_type, out_rs1, out_rs2, out_rd,
           out_imm, out_opcode, out_funct3, out_funct7, out_illegal, out_is_muldiv
  );
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage: combinational decode into a BUF_DEPTH-entry FIFO of records.
// Define RV32M_EN to decode the M extension (funct7 = 0000001 on OP) as legal.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           nRst,
  input  logic                           flush,
  decode_if.slave                        bus,
  output logic [$clog2(BUF_DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_SB  = 3'd3;
  localparam logic [2:0] T_UJ  = 3'd4;
  localparam logic [2:0] T_U   = 3'd5;
  localparam logic [2:0] T_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      typ;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            illegal;
    logic            is_muldiv;
  } rec_t;

  function automatic rec_t decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    rec_t               r;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic signed [31:0] imm32;
    logic               ok;
    opc   = inst[6:0];
    f3    = inst[14:12];
    f7    = inst[31:25];
    r     = '0;
    r.pc  = pc;
    r.opcode = opc;
    imm32 = '0;
    ok    = (inst[1:0] == 2'b11);
    case (opc)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
        r.typ    = T_I;
        r.rs1    = inst[19:15];
        r.rd     = inst[11:7];
        r.funct3 = f3;
        imm32    = {{20{inst[31]}}, inst[31:20]};
        // Shift-immediates carry the arithmetic/logical selector in funct7.
        if (opc == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101)) r.funct7 = f7;
      end
      7'b0110011: begin
        r.typ    = T_R;
        r.rs1    = inst[19:15];
        r.rs2    = inst[24:20];
        r.rd     = inst[11:7];
        r.funct3 = f3;
        r.funct7 = f7;
        if (f7 != 7'b0000000 && f7 != 7'b0100000) begin
`ifdef RV32M_EN
          if (f7 == 7'b0000001) r.is_muldiv = 1'b1;
          else                  ok = 1'b0;
`else
          ok = 1'b0;
`endif
        end
      end
      7'b0100011: begin
        r.typ    = T_S;
        r.rs1    = inst[19:15];
        r.rs2    = inst[24:20];
        r.funct3 = f3;
        imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        r.typ    = T_SB;
        r.rs1    = inst[19:15];
        r.rs2    = inst[24:20];
        r.funct3 = f3;
        imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b1101111: begin
        r.typ = T_UJ;
        r.rd  = inst[11:7];
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        r.typ = T_U;
        r.rd  = inst[11:7];
        imm32 = {inst[31:12], 12'b0};
      end
      default: ok = 1'b0;
    endcase
    r.imm = XLEN'(imm32);
    if (!ok) begin
      r         = '0;
      r.pc      = pc;
      r.typ     = T_ILL;
      r.illegal = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  rec_t             mem_q [BUF_DEPTH];
  rec_t             mem_d [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rec_t in_rec;
  rec_t out_rec;
  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  assign in_rec    = decode(bus.in_inst, bus.in_pc);
  assign in_ready  = nRst && (cnt_q < CNT_W'(BUF_DEPTH)) && !flush;
  assign out_valid = (cnt_q != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_rec;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state: reset wins over flush, push and pop.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  assign out_rec = out_valid ? mem_q[rd_ptr_q] : '0;

  assign count             = cnt_q;
  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_pc        = out_rec.pc;
  assign bus.out_type      = out_rec.typ;
  assign bus.out_rs1       = out_rec.rs1;
  assign bus.out_rs2       = out_rec.rs2;
  assign bus.out_rd        = out_rec.rd;
  assign bus.out_imm       = out_rec.imm;
  assign bus.out_opcode    = out_rec.opcode;
  assign bus.out_funct3    = out_rec.funct3;
  assign bus.out_funct7    = out_rec.funct7;
  assign bus.out_illegal   = out_rec.illegal;
  assign bus.out_is_muldiv = out_rec.is_muldiv;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32, BUF_DEPTH=2) with a scoreboard queue
// of expected records; compile with or without RV32M_EN.
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  typ;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ill;
    logic        md;
  } exp_t;

  logic       clk = 1'b0;
  logic       nRst;
  logic       flush;
  logic [1:0] count;

  decode_if #(.XLEN(XLEN)) bus ();

  decode_stage #(.XLEN(XLEN), .BUF_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .nRst  (nRst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t q[$];
  exp_t exp_in;
  exp_t e_mul;

  function automatic exp_t mk(logic [31:0] pc, logic [2:0] typ, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [31:0] imm, logic [2:0] f3, logic [6:0] f7,
                              logic ill, logic md);
    exp_t e;
    e.pc = pc; e.typ = typ; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.imm = imm; e.f3 = f3; e.f7 = f7; e.ill = ill; e.md = md;
    return e;
  endfunction

  function automatic exp_t ill_rec(logic [31:0] pc);
    return mk(pc, 3'd7, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 7'd0, 1'b1, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: inputs are already driven; sample mid-cycle, update the scoreboard
  // with what the coming edge will do, then advance to the next falling edge.
  task automatic cycle(output bit acc);
    exp_t h;
    #1;
    acc = bus.in_valid && bus.in_ready;
    chk("count", 64'(count), 64'(q.size()));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(nRst && !flush && q.size() < DEPTH));
    if (q.size() != 0) begin
      h = q[0];
      chk("pc", 64'(bus.out_pc), 64'(h.pc));
      chk("type", 64'(bus.out_type), 64'(h.typ));
      chk("rs1", 64'(bus.out_rs1), 64'(h.rs1));
      chk("rs2", 64'(bus.out_rs2), 64'(h.rs2));
      chk("rd", 64'(bus.out_rd), 64'(h.rd));
      chk("imm", 64'(bus.out_imm), 64'(h.imm));
      chk("funct3", 64'(bus.out_funct3), 64'(h.f3));
      chk("funct7", 64'(bus.out_funct7), 64'(h.f7));
      chk("illegal", 64'(bus.out_illegal), 64'(h.ill));
      chk("is_muldiv", 64'(bus.out_is_muldiv), 64'(h.md));
    end else begin
      chk("empty_type", 64'(bus.out_type), 64'(0));
      chk("empty_imm", 64'(bus.out_imm), 64'(0));
      chk("empty_illegal", 64'(bus.out_illegal), 64'(0));
      chk("empty_muldiv", 64'(bus.out_is_muldiv), 64'(0));
    end
    if (!nRst || flush) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
      if (acc) q.push_back(exp_in);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic send(input logic [31:0] inst, input exp_t e);
    bit acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = e.pc;
    exp_in       = e;
    for (int i = 0; i < 20; i++) begin
      cycle(acc);
      if (acc) break;
    end
    chk("send_accepted", 64'(acc), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      idle(1);
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    nRst          = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'd0;
    bus.in_pc     = 32'd0;
    bus.out_ready = 1'b1;
    exp_in        = ill_rec(32'd0);
    @(posedge clk);
    @(negedge clk);

    // Reset state
    idle(2);
    nRst = 1'b1;
    idle(1);

    // Single-cycle latency, then a streamed mix of formats
    send(32'hFFF30293, mk(32'h100, 3'd1, 5'd6, 5'd0, 5'd5, 32'hFFFFFFFF, 3'd0, 7'd0, 1'b0, 1'b0));
    idle(1);
    send(32'h00712423, mk(32'h104, 3'd2, 5'd2, 5'd7, 5'd0, 32'd8, 3'd2, 7'd0, 1'b0, 1'b0));
    send(32'hFE208EE3, mk(32'h108, 3'd3, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 3'd0, 7'd0, 1'b0, 1'b0));
`ifdef RV32M_EN
    e_mul = mk(32'h10C, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 3'd0, 7'd1, 1'b0, 1'b1);
`else
    e_mul = ill_rec(32'h10C);
`endif
    send(32'h022081B3, e_mul);
    send(32'h002081B3, mk(32'h110, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 3'd0, 7'd0, 1'b0, 1'b0));
    send(32'h402081B3, mk(32'h114, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 3'd0, 7'h20, 1'b0, 1'b0));
    send(32'h082081B3, ill_rec(32'h118));
    send(32'h40335293, mk(32'h11C, 3'd1, 5'd6, 5'd0, 5'd5, 32'h403, 3'd5, 7'h20, 1'b0, 1'b0));
    send(32'h12345537, mk(32'h120, 3'd5, 5'd0, 5'd0, 5'd10, 32'h12345000, 3'd0, 7'd0, 1'b0, 1'b0));
    send(32'h008000EF, mk(32'h124, 3'd4, 5'd0, 5'd0, 5'd1, 32'd8, 3'd0, 7'd0, 1'b0, 1'b0));
    send(32'h00000000, ill_rec(32'h128));
    send(32'h0000007F, ill_rec(32'h12C));
    send(32'h00000011, ill_rec(32'h130));
    drain();

    // Back-pressure: third op stalls while full, then all drain in order
    bus.out_ready = 1'b0;
    send(32'h00100093, mk(32'h200, 3'd1, 5'd0, 5'd0, 5'd1, 32'd1, 3'd0, 7'd0, 1'b0, 1'b0));
    send(32'h00200113, mk(32'h204, 3'd1, 5'd0, 5'd0, 5'd2, 32'd2, 3'd0, 7'd0, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h00300193;
    bus.in_pc    = 32'h208;
    exp_in       = mk(32'h208, 3'd1, 5'd0, 5'd0, 5'd3, 32'd3, 3'd0, 7'd0, 1'b0, 1'b0);
    cycle(acc);
    chk("full_stall0", 64'(acc), 64'(0));
    cycle(acc);
    chk("full_stall1", 64'(acc), 64'(0));
    chk("full_count", 64'(count), 64'(2));
    bus.out_ready = 1'b1;
    send(32'h00300193, exp_in);
    drain();

    // Flush with a same-cycle push: both buffered ops and the input vanish
    bus.out_ready = 1'b0;
    send(32'h00400213, mk(32'h300, 3'd1, 5'd0, 5'd0, 5'd4, 32'd4, 3'd0, 7'd0, 1'b0, 1'b0));
    send(32'h00500293, mk(32'h304, 3'd1, 5'd0, 5'd0, 5'd5, 32'd5, 3'd0, 7'd0, 1'b0, 1'b0));
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h00600313;
    bus.in_pc    = 32'h308;
    exp_in       = mk(32'h308, 3'd1, 5'd0, 5'd0, 5'd6, 32'd6, 3'd0, 7'd0, 1'b0, 1'b0);
    cycle(acc);
    chk("flush_drop", 64'(acc), 64'(0));
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("flush_count", 64'(count), 64'(0));
    idle(3);

    // Reset mid-stream discards buffered ops
    bus.out_ready = 1'b0;
    send(32'h00700393, mk(32'h400, 3'd1, 5'd0, 5'd0, 5'd7, 32'd7, 3'd0, 7'd0, 1'b0, 1'b0));
    send(32'h00800413, mk(32'h404, 3'd1, 5'd0, 5'd0, 5'd8, 32'd8, 3'd0, 7'd0, 1'b0, 1'b0));
    nRst = 1'b0;
    idle(1);
    nRst = 1'b1;
    chk("reset_count", 64'(count), 64'(0));
    bus.out_ready = 1'b1;
    idle(3);

    // Traffic resumes normally after reset
    send(32'hFFF30293, mk(32'h500, 3'd1, 5'd6, 5'd0, 5'd5, 32'hFFFFFFFF, 3'd0, 7'd0, 1'b0, 1'b0));
    drain();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
